euclid_inverse: RTL and testbench

Parametrised extended-Euclid engine for RSA key generation. Given `phi` and a candidate public exponent `rng_e`, it decides whether gcd(phi, rng_e) = 1. If so, it also produces the private exponent d = rng_e⁻¹ mod phi. It sits between the e-candidate RNG and the key registers, and replaces the plain GCD checker. It has a built-in restoring divider, so it depends on no vendor IP core and works at any operand width.

---
 rtl/euclid_inverse.sv | 150 +++++++++++++++
 tb/tb_euclid_inverse.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/euclid_inverse.sv
`default_nettype none
// ---------------------------------------------------------------------------
// euclid_inverse: extended-Euclid gcd / modular inverse with restoring divider
// Revision: 1.0
// ---------------------------------------------------------------------------
module euclid_inverse #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] phi,
  input  logic [WIDTH-1:0] rng_e,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             should_redo,
  output logic             error,
  output logic [WIDTH-1:0] gcd,
  output logic [WIDTH-1:0] e_key,
  output logic [WIDTH-1:0] d_key
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DIV    = 3'd2,
    S_UPDATE = 3'd3,
    S_FIX    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_r0, r_r1, r_q, r_rem, r_phi;
  logic [WIDTH+1:0] r_t0, r_t1;
  logic [CW-1:0]    r_cnt;

  logic             w_bad_in;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH+1:0] w_prod;
  logic [WIDTH-1:0] w_dkey;

  assign w_bad_in = (phi < WIDTH'(2)) || (rng_e == '0);

  // Partial remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the top bit of the difference acts as the borrow.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_r1};
  assign w_fits  = ~w_diff[WIDTH];

  assign w_prod  = r_t1 * {2'b00, r_q};
  assign w_dkey  = r_t0[WIDTH+1] ? (r_t0[WIDTH-1:0] + r_phi) : r_t0[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = w_bad_in ? S_FIX : S_DIV;
      S_DIV:    if (r_cnt == CW'(WIDTH - 1)) w_next = S_UPDATE;
      S_UPDATE: w_next = (r_rem == '0) ? S_FIX : S_DIV;
      S_FIX:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r0        <= '0;
      r_r1        <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_phi       <= '0;
      r_t0        <= '0;
      r_t1        <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      should_redo <= 1'b0;
      error       <= 1'b0;
      gcd         <= '0;
      e_key       <= '0;
      d_key       <= '0;
    end else begin
      done        <= 1'b0;
      should_redo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            valid <= 1'b0;
            error <= 1'b0;
            d_key <= '0;
          end
        end
        S_LOAD: begin
          r_r0  <= phi;
          r_r1  <= rng_e;
          r_t0  <= '0;
          r_t1  <= (WIDTH+2)'(1);
          r_phi <= phi;
          r_q   <= phi;
          r_rem <= '0;
          r_cnt <= '0;
          e_key <= rng_e;
          error <= w_bad_in;
        end
        S_DIV: begin
          r_q   <= {r_q[WIDTH-2:0], w_fits};
          r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_UPDATE: begin
          r_r0  <= r_r1;
          r_r1  <= r_rem;
          r_t0  <= r_t1;
          r_t1  <= r_t0 - w_prod;
          // Next division's dividend is the current divisor.
          r_q   <= r_r1;
          r_rem <= '0;
          r_cnt <= '0;
        end
        S_FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          gcd  <= error ? '0 : r_r0;
          if (!error && (r_r0 == WIDTH'(1))) begin
            valid <= 1'b1;
            d_key <= w_dkey;
          end else begin
            should_redo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_euclid_inverse.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_euclid_inverse: directed vectors with a scoreboard queue and done monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_euclid_inverse;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] phi = '0;
  logic [W-1:0] rng_e = '0;
  logic         busy, done, valid, should_redo, error;
  logic [W-1:0] gcd, e_key, d_key;

  euclid_inverse #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .phi         (phi),
    .rng_e       (rng_e),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .should_redo (should_redo),
    .error       (error),
    .gcd         (gcd),
    .e_key       (e_key),
    .d_key       (d_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] g;
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic         r;
    logic         er;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic ev, input logic [W-1:0] eg, ed, ee,
                              input logic er, eerr, input int ecyc);
    exp_t x;
    x.v = ev; x.g = eg; x.d = ed; x.e = ee; x.r = er; x.er = eerr; x.cyc = ecyc;
    return x;
  endfunction

  function automatic int lat(input int k, input logic eerr);
    return eerr ? 2 : k * (W + 1) + 2;
  endfunction

  // Monitor: pops one expectation per done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          chk("done_one_cycle", done, 0);
          chk("redo_one_cycle", should_redo, 0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            mon_x = sb.pop_front();
            chk("valid",   valid,       mon_x.v);
            chk("gcd",     gcd,         mon_x.g);
            chk("d_key",   d_key,       mon_x.d);
            chk("e_key",   e_key,       mon_x.e);
            chk("redo",    should_redo, mon_x.r);
            chk("error",   error,       mon_x.er);
            chk("busy_lo", busy,        0);
            chk("latency", cyc,         mon_x.cyc);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic issue(input logic [W-1:0] p, e, input logic ev, input logic [W-1:0] eg, ed,
                       input logic er, eerr, input int k);
    @(negedge clk);
    phi = p; rng_e = e; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back(mk(ev, eg, ed, e, er, eerr, cyc + lat(k, eerr)));
    start = 1'b0;
    chk("valid_cleared", valid, 0);
    chk("dkey_cleared", d_key, 0);
    @(posedge clk); #1;
    chk("busy_hi", busy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic run(input logic [W-1:0] p, e, input logic ev, input logic [W-1:0] eg, ed,
                     input logic er, eerr, input int k);
    issue(p, e, ev, eg, ed, er, eerr, k);
    drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_redo"},  should_redo, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_gcd"},   gcd, 0);
    chk({tag, "_ekey"},  e_key, 0);
    chk({tag, "_dkey"},  d_key, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    //   phi    e    v  gcd  d     redo err k
    run(20,    3,   1, 1,   7,     0,   0,  3);
    run(20,    4,   0, 4,   0,     1,   0,  1);
    run(3120,  17,  1, 1,   2753,  0,   0,  4);
    run(20,    23,  1, 1,   7,     0,   0,  5);
    run(20,    1,   1, 1,   1,     0,   0,  1);
    run(65535, 2,   1, 1,   32768, 0,   0,  2);
    run(12,    18,  0, 6,   0,     1,   0,  3);
    run(2,     1,   1, 1,   1,     0,   0,  1);
    run(7,     7,   0, 7,   0,     1,   0,  1);
    run(1,     5,   0, 0,   0,     1,   1,  0);
    run(20,    0,   0, 0,   0,     1,   1,  0);
    run(0,     0,   0, 0,   0,     1,   1,  0);

    // A start pulse while busy must not launch a second run.
    issue(35, 12, 1, 1, 3, 0, 0, 3);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of a division.
    issue(20, 3, 1, 1, 7, 0, 0, 3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run(20, 3, 1, 1, 7, 0, 0, 3);

    // start held high across two back-to-back runs.
    @(negedge clk);
    phi = 20; rng_e = 4; start = 1'b1;
    @(posedge clk); #1;
    sa = cyc;
    sb.push_back(mk(0, 4, 0, 4, 1, 0, sa + lat(1, 0)));
    sb.push_back(mk(1, 1, 7, 3, 0, 0, sa + lat(1, 0) + 1 + lat(3, 0)));
    @(posedge clk); #1;
    phi = 20; rng_e = 3;
    while (cyc < sa + lat(1, 0) + 1) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    drain();

    repeat (100) @(posedge clk);
    chk("idle_no_extra", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
